// File: rtl/capture_pkg.sv
// capture_pkg: shared AXI constants, FSM encoding and burst sizing for the capture readback path
package capture_pkg;
    localparam logic [2:0] AXI_SIZE_64B = 3'd6;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int BYTES_PER_WORD = 64;
    localparam int BOUNDARY_4K = 4096;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
    // Beats in the next burst: limited by burst cap, remaining words and the 4 KB page end
    function automatic logic [31:0] burst_len(input logic [11:0] off, input logic [31:0] left,
                                              input logic [31:0] max_burst);
        logic [31:0] to_4k;
        logic [31:0] cap;
        to_4k = (32'(BOUNDARY_4K) - {20'b0, off}) / 32'(BYTES_PER_WORD);
        cap = (left < max_burst) ? left : max_burst;
        return (cap < to_4k) ? cap : to_4k;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic full, do_pop, do_push;
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            assert (!(push && full && !do_pop)) else $error("sync_fifo: push into full fifo");
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/capture_readback.sv
// capture_readback: reads a captured DDR region over AXI4 bursts and replays it as an AXI-Stream
module capture_readback
    import capture_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 34,
    parameter int ID_WIDTH = 6,
    parameter int MAX_BURST = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_aresetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [31:0]           word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t state;
    logic [31:0] cnt, req_left, out_cnt, outstanding, r_left, beat;
    logic [31:0] next_len, ar_len, r_len;
    logic [11:0] r_off;
    logic [CW-1:0] fifo_count;
    logic push, pop, fifo_empty, ar_hs, credit_ok, r_last_exp;
    logic unused_rid;
    assign unused_rid = ^m_axi_rid;
    assign m_axi_arid = '0;
    assign m_axi_arsize = AXI_SIZE_64B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_rready = busy;
    assign m_axis_tkeep = '1;
    assign push = m_axi_rvalid && m_axi_rready;
    assign pop = m_axis_tvalid && m_axis_tready;
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tlast = m_axis_tvalid && out_cnt == cnt - 32'd1;
    assign ar_hs = m_axi_arvalid && m_axi_arready;
    assign ar_len = {24'b0, m_axi_arlen} + 32'd1;
    assign next_len = burst_len(m_axi_araddr[11:0], req_left, 32'(MAX_BURST));
    // Only request what the FIFO is guaranteed to absorb, so R is never back-pressured
    assign credit_ok = 32'(FIFO_DEPTH) >= 32'(fifo_count) + outstanding + next_len;
    // The R side replays the AR burst sizing to know where each rlast belongs
    assign r_len = burst_len(r_off, r_left, 32'(MAX_BURST));
    assign r_last_exp = beat + 32'd1 == r_len;
    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (m_axi_aclk),
        .rst_n (m_axi_aresetn),
        .push  (push),
        .wdata (m_axi_rdata),
        .pop   (pop),
        .rdata (m_axis_tdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state <= ST_IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr <= '0;
            m_axi_arlen <= '0;
            cnt <= '0;
            req_left <= '0;
            out_cnt <= '0;
            outstanding <= '0;
            r_left <= '0;
            r_off <= '0;
            beat <= '0;
        end else begin
            done <= 1'b0;
            outstanding <= outstanding + (ar_hs ? ar_len : 32'd0) - 32'(push);
            if (pop) out_cnt <= out_cnt + 32'd1;
            if (push) begin
                if (m_axi_rresp != AXI_RESP_OKAY || m_axi_rlast != r_last_exp) err <= 1'b1;
                beat <= r_last_exp ? 32'd0 : beat + 32'd1;
                if (r_last_exp) begin
                    r_off <= r_off + 12'(r_len << 6);
                    r_left <= r_left - r_len;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        cnt <= word_count;
                        req_left <= word_count;
                        r_left <= word_count;
                        out_cnt <= '0;
                        beat <= '0;
                        m_axi_araddr <= {start_addr[ADDR_WIDTH-1:6], 6'b0};
                        r_off <= {start_addr[11:6], 6'b0};
                        if (word_count == '0) done <= 1'b1;
                        else begin
                            busy <= 1'b1;
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (ar_hs) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_araddr <= m_axi_araddr + ADDR_WIDTH'(ar_len << 6);
                        req_left <= req_left - ar_len;
                        if (req_left == ar_len) state <= ST_DRAIN;
                    end else if (!m_axi_arvalid && req_left != '0 && credit_ok) begin
                        m_axi_arvalid <= 1'b1;
                        m_axi_arlen <= 8'(next_len - 32'd1);
                    end
                end
                ST_DRAIN: begin
                    if (pop && m_axis_tlast) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_capture_readback.sv
// tb_capture_readback: randomized AXI slave and stream sink checked against an address-rule model
module tb_capture_readback;
    localparam int DW = 512;
    localparam int AW = 34;
    typedef struct {logic [AW-1:0] addr; int len;} ar_t;
    typedef struct {logic [DW-1:0] d; logic l;} w_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [31:0] word_count = '0;
    logic busy, done, err, arvalid, rready, tlast, tvalid;
    logic [5:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst;
    logic arready = 1'b0;
    logic [5:0] rid = '0;
    logic [DW-1:0] rdata = '0;
    logic [1:0] rresp = '0;
    logic rlast = 1'b0;
    logic rvalid = 1'b0;
    logic [DW-1:0] tdata;
    logic [63:0] tkeep;
    logic tready = 1'b0;
    int checks = 0, errors = 0;
    ar_t ar_q[$], ar_log[$];
    w_t out_q[$];
    int beat = 0, gbeat = 0, inject = -1, tmode = 0, cyc = 0;
    int done_cnt = 0, done_base = 0, done_cyc = 0, tlast_cyc = 0;
    int arb_total = 0, popped = 0, max_inflight = 0, proto_viol = 0, arvalid_cnt = 0;
    bit busy_seen = 0;
    bit s_ar, s_r, s_ax, p_tv, p_tr, p_tl, p_av, p_arr;
    logic [DW-1:0] p_td;
    logic [AW-1:0] p_aa;
    logic [7:0] p_al;
    always #5 clk = ~clk;
    capture_readback dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n), .start(start), .start_addr(start_addr),
        .word_count(word_count), .busy(busy), .done(done), .err(err),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axis_tdata(tdata), .m_axis_tkeep(tkeep),
        .m_axis_tlast(tlast), .m_axis_tvalid(tvalid), .m_axis_tready(tready)
    );
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {16{a[31:0] ^ 32'h5A5A_5A5A}};
    endfunction
    function automatic int words_bad(input logic [AW-1:0] base, input int n);
        int b;
        b = (out_q.size() != n) ? 1 : 0;
        for (int i = 0; i < out_q.size() && i < n; i++) begin
            if (out_q[i].d !== mem_word(base + AW'(i * 64))) b++;
            if (out_q[i].l !== (i == n - 1)) b++;
        end
        return b;
    endfunction
    // Expected bursts: contiguous, each as long as the 16-beat cap, remaining words and 4 KB page allow
    function automatic int ars_bad(input logic [AW-1:0] base, input int n);
        logic [AW-1:0] a;
        int left, b, lim, to4k;
        a = base;
        left = n;
        b = 0;
        foreach (ar_log[k]) begin
            to4k = (4096 - int'(a[11:0])) / 64;
            lim = left < 16 ? left : 16;
            lim = lim < to4k ? lim : to4k;
            if (ar_log[k].addr !== a || ar_log[k].len != lim || lim < 1) b++;
            a = a + AW'(lim * 64);
            left -= lim;
        end
        return b + (left != 0 ? 1 : 0);
    endfunction
    always begin
        @(negedge clk);
        cyc++;
        s_ar = arvalid && arready;
        s_r = rvalid && rready;
        s_ax = tvalid && tready;
        if (!rst_n) begin
            p_tv = 0;
            p_av = 0;
        end else begin
            if (p_tv && !p_tr && (!tvalid || tdata !== p_td || tlast !== p_tl)) proto_viol++;
            if (p_av && !p_arr && (!arvalid || araddr !== p_aa || arlen !== p_al)) proto_viol++;
            p_tv = tvalid; p_tr = tready; p_td = tdata; p_tl = tlast;
            p_av = arvalid; p_arr = arready; p_aa = araddr; p_al = arlen;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (arvalid) arvalid_cnt++;
        if (busy) busy_seen = 1;
        if (s_ax) begin
            out_q.push_back('{tdata, tlast});
            popped++;
            if (tlast) tlast_cyc = cyc;
        end
        if (s_ar) begin
            ar_q.push_back('{araddr, int'(arlen) + 1});
            ar_log.push_back('{araddr, int'(arlen) + 1});
            arb_total += int'(arlen) + 1;
        end
        if (arb_total - popped > max_inflight) max_inflight = arb_total - popped;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            ar_q.delete();
            beat = 0;
            rvalid = 0;
            rlast = 0;
            rresp = 0;
            arready = 0;
        end else begin
            if (s_r && ar_q.size() > 0) begin
                gbeat++;
                if (beat == ar_q[0].len - 1) begin
                    void'(ar_q.pop_front());
                    beat = 0;
                end else beat++;
            end
            if (!rvalid || s_r) begin
                if (ar_q.size() > 0 && $urandom_range(3) != 0) begin
                    rvalid = 1;
                    rdata = mem_word(ar_q[0].addr + AW'(beat * 64));
                    rlast = beat == ar_q[0].len - 1;
                    rresp = (gbeat == inject) ? 2'b10 : 2'b00;
                end else rvalid = 0;
            end
            arready = 1'($urandom_range(1));
        end
        tready = tmode == 0 ? 1'b1 : tmode == 1 ? 1'b0 : 1'($urandom_range(1));
    end
    task automatic start_op(input logic [AW-1:0] a, input int n);
        out_q.delete();
        ar_log.delete();
        arb_total = 0;
        popped = 0;
        max_inflight = 0;
        gbeat = 0;
        busy_seen = 0;
        done_base = done_cnt;
        @(posedge clk);
        #1;
        start_addr = a;
        word_count = n;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
    endtask
    task automatic wait_done(input int budget, output bit to);
        to = 1;
        for (int i = 0; i < budget && to; i++) begin
            @(posedge clk);
            if (done_cnt > done_base) to = 0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err, arvalid, tvalid, tlast, rready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0", {busy, done, err, arvalid, tvalid, tlast, rready});
        end
        checks++;
        if (araddr !== '0 || arlen !== '0) begin
            errors++;
            $display("FAIL reset_ar got addr %0h len %0d exp 0 0", araddr, arlen);
        end
        rst_n = 1;
        repeat (2) @(posedge clk);
    endtask
    task automatic test_single_burst;
        bit to;
        tmode = 0;
        start_op(34'h1000, 16);
        wait_done(2000, to);
        checks++;
        if (to) begin errors++; $display("FAIL t1_timeout got no done exp done"); end
        checks++;
        if (ar_log.size() != 1 || ar_log[0].addr !== 34'h1000 || ar_log[0].len != 16) begin
            errors++;
            $display("FAIL t1_ar got %0d bursts exp one at 1000 len 16", ar_log.size());
        end
        checks++;
        if (words_bad(34'h1000, 16) != 0) begin
            errors++;
            $display("FAIL t1_words got %0d bad exp 0", words_bad(34'h1000, 16));
        end
        checks++;
        if (done_cyc != tlast_cyc + 1) begin
            errors++;
            $display("FAIL t1_done_lat got %0d exp %0d", done_cyc, tlast_cyc + 1);
        end
        checks++;
        if (arsize !== 3'd6 || arburst !== 2'b01 || arid !== '0 || tkeep !== '1 || err !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL t1_static got size %0d burst %0d err %0b busy %0b exp 6 1 0 0", arsize, arburst, err, busy);
        end
    endtask
    task automatic test_boundary;
        bit to;
        start_op(34'h0FC0, 4);
        wait_done(2000, to);
        checks++;
        if (to) begin errors++; $display("FAIL t2_timeout got no done exp done"); end
        checks++;
        if (ar_log.size() != 2 || ar_log[0].addr !== 34'h0FC0 || ar_log[0].len != 1 ||
            ar_log[1].addr !== 34'h1000 || ar_log[1].len != 3) begin
            errors++;
            $display("FAIL t2_ar got %0d bursts exp FC0/1 then 1000/3", ar_log.size());
        end
        checks++;
        if (words_bad(34'h0FC0, 4) != 0) begin
            errors++;
            $display("FAIL t2_words got %0d bad exp 0", words_bad(34'h0FC0, 4));
        end
    endtask
    task automatic test_backpressure;
        bit to;
        logic [AW-1:0] base;
        int nl;
        base = AW'($urandom & 32'hFFFF_FFC0);
        tmode = 1;
        start_op(base, 100);
        repeat (500) @(posedge clk);
        tmode = 2;
        wait_done(5000, to);
        checks++;
        if (to) begin errors++; $display("FAIL t3_timeout got no done exp done"); end
        checks++;
        if (max_inflight > 32) begin
            errors++;
            $display("FAIL t3_credit got %0d in flight exp <= 32", max_inflight);
        end
        checks++;
        if (words_bad(base, 100) != 0) begin
            errors++;
            $display("FAIL t3_words got %0d bad exp 0", words_bad(base, 100));
        end
        nl = 0;
        foreach (out_q[i]) nl += int'(out_q[i].l);
        checks++;
        if (nl != 1 || ars_bad(base, 100) != 0 || proto_viol != 0) begin
            errors++;
            $display("FAIL t3_rules got tlasts %0d arbad %0d proto %0d exp 1 0 0", nl, ars_bad(base, 100), proto_viol);
        end
        tmode = 0;
    endtask
    task automatic test_rresp_err;
        bit to;
        inject = 2;
        start_op(34'h4000, 8);
        wait_done(2000, to);
        inject = -1;
        checks++;
        if (to || err !== 1) begin
            errors++;
            $display("FAIL t4_err got err %0b timeout %0b exp 1 0", err, to);
        end
        checks++;
        if (words_bad(34'h4000, 8) != 0) begin
            errors++;
            $display("FAIL t4_words got %0d bad exp 0", words_bad(34'h4000, 8));
        end
        start_op(34'h4400, 1);
        checks++;
        if (err !== 0) begin errors++; $display("FAIL t4_clear got err %0b exp 0", err); end
        wait_done(2000, to);
        checks++;
        if (to || err !== 0 || words_bad(34'h4400, 1) != 0) begin
            errors++;
            $display("FAIL t4_next got err %0b timeout %0b exp 0 0", err, to);
        end
    endtask
    task automatic test_zero_and_busy;
        bit to;
        int arv0;
        arv0 = arvalid_cnt;
        start_op(34'h0100, 0);
        wait_done(20, to);
        repeat (4) @(posedge clk);
        checks++;
        if (to || done_cnt != done_base + 1 || busy_seen || arvalid_cnt != arv0) begin
            errors++;
            $display("FAIL t5_zero got dones %0d busy %0b ars %0d exp 1 0 0",
                     done_cnt - done_base, busy_seen, arvalid_cnt - arv0);
        end
        start_op(34'h3000, 20);
        repeat (2) @(posedge clk);
        #1;
        start_addr = 34'h5000;
        word_count = 5;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        wait_done(2000, to);
        repeat (5) @(posedge clk);
        checks++;
        if (to || done_cnt != done_base + 1 || words_bad(34'h3000, 20) != 0) begin
            errors++;
            $display("FAIL t5_busy_start got dones %0d bad %0d exp 1 0",
                     done_cnt - done_base, words_bad(34'h3000, 20));
        end
    endtask
    task automatic test_reset_mid;
        bit to;
        tmode = 2;
        start_op(34'h2000, 64);
        repeat (15) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        checks++;
        if ({busy, done, err, arvalid, tvalid, tlast, rready} !== 7'b0 || araddr !== '0 || arlen !== '0) begin
            errors++;
            $display("FAIL t6_abort got %b addr %0h exp 0 0", {busy, done, err, arvalid, tvalid, tlast, rready}, araddr);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        tmode = 0;
        start_op(34'h2FC0, 10);
        wait_done(2000, to);
        checks++;
        if (to || err !== 0 || words_bad(34'h2FC0, 10) != 0 || ars_bad(34'h2FC0, 10) != 0) begin
            errors++;
            $display("FAIL t6_rerun got timeout %0b err %0b bad %0d exp 0 0 0", to, err, words_bad(34'h2FC0, 10));
        end
    endtask
    task automatic test_random;
        bit to;
        logic [AW-1:0] a, base;
        int n;
        for (int k = 0; k < 5; k++) begin
            a = AW'({$urandom_range(255), 12'h0}) + AW'(4096 - 64 * $urandom_range(1, 20)) + AW'($urandom_range(63));
            base = {a[AW-1:6], 6'b0};
            n = $urandom_range(1, 70);
            tmode = $urandom_range(1) * 2;
            start_op(a, n);
            wait_done(4000, to);
            checks++;
            if (to || err !== 0 || words_bad(base, n) != 0 || ars_bad(base, n) != 0 || max_inflight > 32) begin
                errors++;
                $display("FAIL rand%0d got timeout %0b err %0b bad %0d arbad %0d exp 0 0 0 0",
                         k, to, err, words_bad(base, n), ars_bad(base, n));
            end
        end
        checks++;
        if (proto_viol != 0) begin errors++; $display("FAIL protocol got %0d drops exp 0", proto_viol); end
    endtask
    initial begin
        test_reset;
        test_single_burst;
        test_boundary;
        test_backpressure;
        test_rresp_err;
        test_zero_and_busy;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
